dmem_arbiter: RTL and testbench

//  Shares the single-port, word-addressed data memory between two requesters:

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing a single-port word memory between
//            two latched requesters, completing each access with an ack pulse.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [29:0] c_depth = 30'(DEPTH);

  state_t        r_state;
  logic          r_last_grant;
  logic          r_port;
  logic          r_we;
  logic          r_ok;
  logic          r_mem_we;
  logic [31:0]   r_mem_a;
  logic [DW-1:0] r_mem_wd;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_err0;
  logic          r_err1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic [1:0]    r_ack_d;

  logic          w_elig0;
  logic          w_elig1;
  logic          w_any;
  logic          w_gnt;
  logic          w_sel_we;
  logic          w_sel_ok;
  logic [31:0]   w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < c_depth);
  endfunction

  // A port is blind during its ack cycle and the one after, so a requester
  // that drops req on seeing ack never causes a duplicate access.
  always_comb begin
    w_elig0 = p0_req & ~r_ack0 & ~r_ack_d[0];
    w_elig1 = p1_req & ~r_ack1 & ~r_ack_d[1];
    w_any   = w_elig0 | w_elig1;
    if (w_elig0 && w_elig1) begin
      w_gnt = ~r_last_grant;
    end else begin
      w_gnt = w_elig1;
    end
    w_sel_we    = w_gnt ? p1_we    : p0_we;
    w_sel_addr  = w_gnt ? p1_addr  : p0_addr;
    w_sel_wdata = w_gnt ? p1_wdata : p0_wdata;
    w_sel_ok    = addr_ok(w_sel_addr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_ok         <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_a      <= '0;
      r_mem_wd     <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_ack_d      <= 2'b00;
    end else begin
      r_ack_d <= {r_ack1, r_ack0};
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_port       <= w_gnt;
            r_last_grant <= w_gnt;
            r_we         <= w_sel_we;
            r_ok         <= w_sel_ok;
            r_mem_a      <= w_sel_addr;
            r_mem_wd     <= w_sel_wdata;
            r_mem_we     <= w_sel_we & w_sel_ok;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
          if (r_port) begin
            r_rdata1 <= (r_we || !r_ok) ? '0 : mem_rd;
            r_ack1   <= 1'b1;
            r_err1   <= ~r_ok;
          end else begin
            r_rdata0 <= (r_we || !r_ok) ? '0 : mem_rd;
            r_ack0   <= 1'b1;
            r_err0   <= ~r_ok;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset landing on the write edge must suppress the write itself.
  assign mem_we   = r_mem_we & ~reset;
  assign mem_a    = r_mem_a;
  assign mem_wd   = r_mem_wd;
  assign p0_ack   = r_ack0;
  assign p1_ack   = r_ack1;
  assign p0_err   = r_err0;
  assign p1_err   = r_err1;
  assign p0_rdata = r_rdata0;
  assign p1_rdata = r_rdata1;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Testbench for dmem_arbiter: directed table, multi-cycle corner sequences and
// randomized two-port traffic against a transaction-level memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_we, busy;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int n_cmp, n_bad, we_cnt;

  typedef struct {
    bit          p;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_wes;
  } vec_t;

  vec_t vecs [12];

  dmem_arbiter #(.DEPTH(64), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  assign mem_rd = mem[mem_a[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit addr_valid(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'd64);
  endfunction

  function automatic bit ack_of(input bit p);
    return p ? p1_ack : p0_ack;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory semantics: reads return current contents, invalid addresses read 0
  // and never write.
  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output bit eerr);
    bit v;
    v    = addr_valid(a);
    eerr = !v;
    erd  = (!we && v) ? ref_mem[a[7:2]] : 32'h0;
    if (we && v) ref_mem[a[7:2]] = wd;
  endtask

  task automatic drive(input bit p, input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin
      p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = wd;
    end
  endtask

  task automatic wait_ack(input bit p, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack_of(p) && lat < 20);
  endtask

  task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output bit err, output int lat, output int wes);
    int w0;
    repeat (3) @(negedge clk);
    w0 = we_cnt;
    drive(p, 1'b1, we, a, wd);
    wait_ack(p, lat);
    rd  = p ? p1_rdata : p0_rdata;
    err = p ? p1_err : p0_err;
    wes = we_cnt - w0;
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rand_port(input bit p, input int n);
    logic [31:0] a, wd, ard, erd;
    bit          we, aerr, eerr;
    int          lat, sel;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(3, 6)) @(negedge clk);
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = 32'($urandom_range(0, 7)) << 2;
      else if (sel == 6) a = 32'($urandom_range(0, 63)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else               a = 32'h100 + (32'($urandom_range(0, 255)) << 2);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      drive(p, 1'b1, we, a, wd);
      wait_ack(p, lat);
      ard  = p ? p1_rdata : p0_rdata;
      aerr = p ? p1_err : p0_err;
      drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
      chk(lat >= 2 && lat <= 5, "rand_latency", 32'(lat), 32'd5);
      if (lat < 20) begin
        model(we, a, wd, erd, eerr);
        chk(ard == erd, "rand_rdata", ard, erd);
        chk(aerr == eerr, "rand_err", 32'(aerr), 32'(eerr));
      end
    end
  endtask

  logic [31:0] rd, erd;
  bit          er, eerr;
  int          lat, wes, w0, acks_seen;
  int          ack_port [4];
  int          ack_cyc [4];
  int          exp_port [4] = '{0, 1, 0, 1};
  int          exp_cyc [4]  = '{2, 5, 8, 11};

  initial begin
    n_cmp = 0; n_bad = 0; we_cnt = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      mem[i]     <= 32'h0;
      ref_mem[i]  = 32'h0;
    end

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0,         1'b0, 1};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0006, 32'h1111_1111, 32'h0,         1'b1, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0,         1'b0, 1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_BAD0, 32'h0,         1'b1, 0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 0};

    fork
      forever begin
        @(negedge clk);
        chk(!(p0_ack && p1_ack) && !(p0_err && !p0_ack) && !(p1_err && !p1_ack),
            "ack_err_exclusive", {28'h0, p0_ack, p0_err, p1_ack, p1_err}, 32'h0);
        if (mem_we) begin
          we_cnt++;
          chk(addr_valid(mem_a), "mem_we_addr_valid", mem_a, 32'h0);
        end
      end
      forever begin
        @(posedge clk);
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk({p0_ack, p1_ack, p0_err, p1_err, mem_we, busy} == 6'b0, "reset_flags",
        {26'h0, p0_ack, p1_ack, p0_err, p1_err, mem_we, busy}, 32'h0);
    chk(p0_rdata == 32'h0, "reset_p0_rdata", p0_rdata, 32'h0);
    chk(p1_rdata == 32'h0, "reset_p1_rdata", p1_rdata, 32'h0);
    chk(mem_a == 32'h0, "reset_mem_a", mem_a, 32'h0);
    chk(mem_wd == 32'h0, "reset_mem_wd", mem_wd, 32'h0);

    // Both ports requesting from reset: p0 first, then strict alternation.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
    acks_seen = 0;
    for (int c = 1; c <= 20 && acks_seen < 4; c++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) begin
        ack_port[acks_seen] = p1_ack ? 1 : 0;
        ack_cyc[acks_seen]  = c;
        acks_seen++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(acks_seen == 4, "tie_ack_count", 32'(acks_seen), 32'd4);
    for (int i = 0; i < 4 && i < acks_seen; i++) begin
      chk(ack_port[i] == exp_port[i], $sformatf("tie_port%0d", i), 32'(ack_port[i]), 32'(exp_port[i]));
      chk(ack_cyc[i] == exp_cyc[i], $sformatf("tie_cycle%0d", i), 32'(ack_cyc[i]), 32'(exp_cyc[i]));
    end

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wd, rd, er, lat, wes);
      model(vecs[i].we, vecs[i].addr, vecs[i].wd, erd, eerr);
      chk(lat == 2, $sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk(rd == vecs[i].exp_rd, $sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk(er == vecs[i].exp_err, $sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk(wes == vecs[i].exp_wes, $sformatf("vec%0d_mem_we_pulses", i), 32'(wes), 32'(vecs[i].exp_wes));
    end

    // Reset arriving during the ACCESS cycle of a p1 write aborts it.
    repeat (3) @(negedge clk);
    w0 = we_cnt;
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h1234);
    @(posedge clk); #1;
    chk(busy == 1'b1, "abort_busy_in_access", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk(busy == 1'b0, "abort_busy_cleared", 32'(busy), 32'd0);
    chk(p1_ack == 1'b0, "abort_no_ack_in_reset", 32'(p1_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk(!p1_ack && !busy, "abort_stays_idle", {30'h0, p1_ack, busy}, 32'h0);
    end
    chk(we_cnt == w0, "abort_no_mem_we", 32'(we_cnt - w0), 32'd0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, wes);
    model(1'b0, 32'h20, 32'h0, erd, eerr);
    chk(rd != 32'h1234 && rd == erd, "abort_readback", rd, erd);

    // Requester holds req one cycle past its ack: no second access.
    repeat (3) @(negedge clk);
    w0 = we_cnt;
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h55AA_0F0F);
    wait_ack(1'b0, lat);
    model(1'b1, 32'h30, 32'h55AA_0F0F, erd, eerr);
    chk(lat == 2, "hold_latency", 32'(lat), 32'd2);
    chk(p0_err == eerr, "hold_err", 32'(p0_err), 32'(eerr));
    @(posedge clk);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) begin
      @(posedge clk); #1;
      chk(!busy && !p0_ack, "hold_no_reaccess", {30'h0, busy, p0_ack}, 32'h0);
    end
    chk(we_cnt - w0 == 1, "hold_single_write", 32'(we_cnt - w0), 32'd1);
    txn(1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat, wes);
    model(1'b0, 32'h30, 32'h0, erd, eerr);
    chk(rd == erd, "hold_readback", rd, erd);
    chk(lat == 2, "hold_next_latency", 32'(lat), 32'd2);

    fork
      rand_port(1'b0, 40);
      rand_port(1'b1, 40);
    join

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
